// File: rtl/z2_mem_arbiter.sv
// Memory arbiter for a Zorro-style card. A single SDRAM-like command port is
// shared between refresh, video scanout bursts and Zorro bus accesses.
// Priority in IDLE: refresh > starved Zorro > video > Zorro.
module z2_mem_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int VID_BURST        = 8,
  parameter int STARVE_LIMIT     = 64
) (
  input  logic        z_sample_clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_grant,
  output logic        vid_rdata_valid,
  input  logic        zorro_req,
  input  logic        zorro_write,
  input  logic [23:0] zorro_addr,
  input  logic [15:0] zorro_wdata,
  input  logic [1:0]  zorro_be,
  output logic        zorro_ack,
  output logic [15:0] zorro_rdata,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic        mem_cmd_refresh,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_rdata_valid,
  input  logic [15:0] mem_rdata
);

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int CW = $clog2(VID_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_INTERVAL - 1);
  localparam logic [CW-1:0] BURST_N    = CW'(VID_BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(VID_BURST - 1);
  localparam logic [SW-1:0] STARVE_N   = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_VIDEO, S_ZORRO, S_ZWAIT} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] ref_cnt_q;
  logic          ref_pend_q, ref_clr;
  logic [SW-1:0] wait_q, wait_d;
  logic [CW-1:0] iss_q, iss_d, ret_q, ret_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic          write_q, write_d;
  logic          vgrant_q, vgrant_d;
  logic          zack_q, zack_d;
  logic          zign_q;
  logic [15:0]   zrdata_q, zrdata_d;
  logic          zreq, starved;

  // A request still high in the ack cycle and the one after belongs to the
  // transaction just finished; masking it avoids serving it twice.
  assign zreq    = zorro_req & ~zack_q & ~zign_q;
  assign starved = zreq & (wait_q >= STARVE_N);

  assign vid_grant       = vgrant_q;
  assign vid_rdata_valid = (state_q == S_VIDEO) & mem_rdata_valid;
  assign zorro_ack       = zack_q;
  assign zorro_rdata     = zrdata_q;
  assign mem_cmd_write   = (state_q == S_ZORRO) & write_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_be          = be_q;

  // Free-running refresh timer; pending flag is sticky, so back-to-back
  // expiries while stalled still produce only one refresh.
  always_ff @(posedge z_sample_clk or posedge reset) begin
    if (reset) begin
      ref_cnt_q  <= REF_RELOAD;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= (ref_cnt_q == '0) ? REF_RELOAD : ref_cnt_q - 1'b1;
      ref_pend_q <= (ref_pend_q & ~ref_clr) | (ref_cnt_q == '0);
    end
  end

  // Next-state, command outputs and datapath updates.
  always_comb begin
    state_d         = state_q;
    iss_d           = iss_q;
    ret_d           = ret_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    write_d         = write_q;
    vgrant_d        = 1'b0;
    zack_d          = 1'b0;
    zrdata_d        = zrdata_q;
    ref_clr         = 1'b0;
    mem_cmd_valid   = 1'b0;
    mem_cmd_refresh = 1'b0;
    wait_d          = wait_q;

    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_REFRESH;
        end else if (starved || (zreq && !vid_req)) begin
          state_d = S_ZORRO;
          addr_d  = zorro_addr;
          wdata_d = zorro_wdata;
          be_d    = zorro_be;
          write_d = zorro_write;
        end else if (vid_req) begin
          state_d  = S_VIDEO;
          vgrant_d = 1'b1;
          addr_d   = vid_addr;
          be_d     = 2'b11;
          write_d  = 1'b0;
          iss_d    = '0;
          ret_d    = '0;
        end
      end
      S_REFRESH: begin
        mem_cmd_valid   = 1'b1;
        mem_cmd_refresh = 1'b1;
        if (mem_cmd_ready) begin
          ref_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_VIDEO: begin
        mem_cmd_valid = (iss_q != BURST_N);
        if (mem_cmd_valid && mem_cmd_ready) begin
          iss_d  = iss_q + 1'b1;
          addr_d = addr_q + 24'd2;
        end
        if (mem_rdata_valid) begin
          if (ret_q == BURST_LAST) state_d = S_IDLE;
          else                     ret_d   = ret_q + 1'b1;
        end
      end
      S_ZORRO: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          if (write_q) begin
            zack_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ZWAIT;
          end
        end
      end
      S_ZWAIT: begin
        if (mem_rdata_valid) begin
          zrdata_d = mem_rdata;
          zack_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_ZORRO) || (state_q == S_ZWAIT) || !zreq ||
        ((state_q == S_IDLE) && (state_d == S_ZORRO)))
      wait_d = '0;
    else if (wait_q != STARVE_N)
      wait_d = wait_q + 1'b1;
  end

  // FSM and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge z_sample_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      vgrant_q <= 1'b0;
      zack_q   <= 1'b0;
      zign_q   <= 1'b0;
      zrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      write_q  <= write_d;
      vgrant_q <= vgrant_d;
      zack_q   <= zack_d;
      zign_q   <= zack_q;
      zrdata_q <= zrdata_d;
    end
  end

endmodule
